counter_8b_updown: RTL and testbench

- 8-bit synchronous binary up/down counter with an asynchronous active-low clear.
- Used as a general-purpose event/position counter; the direction is selected every cycle by a single control bit.
- Provides registered wrap-event flags and combinational boundary flags so downstream logic can detect overflow and underflow without decoding `count`.

---
 rtl/counter_8b_updown.sv | 58 +++++
 tb/tb_counter_8b_updown.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/counter_8b_updown.sv
// 8-bit up/down counter with an asynchronous active-low clear.
// Provides combinational boundary flags and registered one-cycle wrap pulses.
module counter_8b_updown #(
   parameter int                 WIDTH     = 8,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dir,
   output logic [WIDTH-1:0] count,
   output logic             at_max,
   output logic             at_min,
   output logic             wrap_up,
   output logic             wrap_dn
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   generate
      if (WIDTH != 8) begin : g_width_chk
         $error("counter_8b_updown is fixed at WIDTH = 8");
      end
   endgenerate

   logic [WIDTH-1:0] r_count;
   logic             r_wrap_up;
   logic             r_wrap_dn;

   logic [WIDTH-1:0] w_next;
   logic             w_is_max;
   logic             w_is_min;

   always_comb begin
      w_is_max = (r_count == {WIDTH{1'b1}});
      w_is_min = (r_count == {WIDTH{1'b0}});
      w_next   = dir ? (r_count + ONE) : (r_count - ONE);
   end

   // The wrap pulses are decided from the pre-step value on the same edge as the step.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count   <= RESET_VAL;
         r_wrap_up <= 1'b0;
         r_wrap_dn <= 1'b0;
      end else begin
         r_count   <= w_next;
         r_wrap_up <= dir & w_is_max;
         r_wrap_dn <= ~dir & w_is_min;
      end
   end

   assign count   = r_count;
   assign at_max  = w_is_max;
   assign at_min  = w_is_min;
   assign wrap_up = r_wrap_up;
   assign wrap_dn = r_wrap_dn;

endmodule

// File: tb/tb_counter_8b_updown.sv
// Randomized and directed bench for counter_8b_updown against an arithmetic
// reference model (value modulo 256, wrap events derived from the pre-step value).
module tb_counter_8b_updown;

   logic       clk;
   logic       reset;
   logic       dir;
   logic [7:0] count;
   logic       at_max;
   logic       at_min;
   logic       wrap_up;
   logic       wrap_dn;

   int n_checks;
   int n_pass;

   // reference model state
   int m_cnt;
   int m_wup;
   int m_wdn;

   counter_8b_updown #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
      .clk     (clk),
      .reset   (reset),
      .dir     (dir),
      .count   (count),
      .at_max  (at_max),
      .at_min  (at_min),
      .wrap_up (wrap_up),
      .wrap_dn (wrap_dn)
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input int observed, input int expected);
      n_checks++;
      if (observed == expected) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
   endtask

   task automatic check_all(input string tag);
      check_eq({tag, ".count"},   int'(count),   m_cnt);
      check_eq({tag, ".at_max"},  int'(at_max),  (m_cnt == 255) ? 1 : 0);
      check_eq({tag, ".at_min"},  int'(at_min),  (m_cnt == 0) ? 1 : 0);
      check_eq({tag, ".wrap_up"}, int'(wrap_up), m_wup);
      check_eq({tag, ".wrap_dn"}, int'(wrap_dn), m_wdn);
   endtask

   // driver: set direction, advance model, take one edge, check just after it
   task automatic step(input logic d, input string tag);
      dir = d;
      if (d) begin
         m_wup = (m_cnt == 255) ? 1 : 0;
         m_wdn = 0;
         m_cnt = (m_cnt + 1) % 256;
      end else begin
         m_wup = 0;
         m_wdn = (m_cnt == 0) ? 1 : 0;
         m_cnt = (m_cnt + 255) % 256;
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   // driver: asynchronous reset pulse between edges, held across one edge
   task automatic async_reset(input string tag);
      #2;
      reset = 1'b0;
      m_cnt = 0;
      m_wup = 0;
      m_wdn = 0;
      #1;
      check_all({tag, ".immediate"});
      @(posedge clk);
      #1;
      check_all({tag, ".held"});
      #2;
      reset = 1'b1;
   endtask

   int n_wrap;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      m_cnt    = 0;
      m_wup    = 0;
      m_wdn    = 0;
      reset    = 1'b0;
      dir      = 1'b1;

      // reset state held for 20 ns across edges
      #20;
      check_all("reset");
      #2 reset = 1'b1;

      // count up from reset
      for (int i = 0; i < 8; i++) step(1'b1, "up");
      check_eq("reached_8", int'(count), 8);

      // direction switch: 7, 6, 5 ...
      for (int i = 0; i < 8; i++) step(1'b0, "down");

      // underflow then the pulse clears
      step(1'b0, "underflow");
      check_eq("underflow.pulse", int'(wrap_dn), 1);
      step(1'b0, "after_underflow");

      // now at FE: overflow over two edges
      check_eq("at_fe", int'(count), 8'hFE);
      step(1'b1, "to_ff");
      step(1'b1, "overflow");
      check_eq("overflow.pulse", int'(wrap_up), 1);
      step(1'b1, "after_overflow");

      // climb to 5A then reset between edges
      while (m_cnt != 8'h5A) step(1'b1, "climb");
      async_reset("reset_5a");
      step(1'b1, "resume");

      // full cycle of 256 up-steps from 0
      async_reset("reset_full");
      n_wrap = 0;
      for (int i = 0; i < 256; i++) begin
         step(1'b1, "full");
         if (wrap_up) n_wrap++;
      end
      check_eq("full.count", int'(count), 0);
      check_eq("full.wraps", n_wrap, 1);

      // randomized directions with occasional asynchronous resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) async_reset("rand_reset");
         else if ($urandom_range(0, 9) < 7) step(logic'($urandom_range(0, 1)), "rand");
         else begin
            // runs toward a boundary so wraps get exercised in both directions
            logic d;
            d = logic'($urandom_range(0, 1));
            for (int k = 0; k < 12; k++) step(d, "rand_run");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
